// File: rtl/calc_pkg.sv
// calc_pkg: key codes, ALU op codes and sequencer state encoding shared by the calculator datapath.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd4;
    localparam logic [3:0] KEY_SUB = 4'd5;
    localparam logic [3:0] KEY_MUL = 4'd6;
    localparam logic [3:0] KEY_EQ  = 4'd7;
    localparam logic [3:0] KEY_CLR = 4'd8;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_A  = 3'd1,
        GOT_OP = 3'd2,
        GOT_B  = 3'd3,
        EXEC   = 3'd4,
        SHOW   = 3'd5
    } state_e;

endpackage

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad-entry sequencer feeding a combinational 2-bit ALU and capturing its result.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int SHOW_CYCLES = 0,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] key_code,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_status,
    output logic [3:0] result,
    output logic       status,
    output logic       result_valid,
    output logic       err,
    output logic [2:0] state_dbg
);

    state_e           state_q, state_d;
    logic [1:0]       a_q, a_d, b_q, b_d, op_q, op_d;
    logic [3:0]       res_q, res_d;
    logic             sts_q, sts_d, err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc, is_dig, is_op, is_eq, is_clr, is_bad, timeout;

    assign key_ready    = state_q != EXEC;
    assign acc          = key_valid && key_ready;
    assign is_dig       = key_code < KEY_ADD;
    assign is_op        = key_code >= KEY_ADD && key_code <= KEY_MUL;
    assign is_eq        = key_code == KEY_EQ;
    assign is_clr       = key_code == KEY_CLR;
    assign is_bad       = key_code > KEY_CLR;
    // >= rather than == so a key accepted on the last hold cycle only defers the timeout
    assign timeout      = SHOW_CYCLES > 0 && state_q == SHOW && cnt_q >= CNT_W'(SHOW_CYCLES - 1);

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = op_q;
    assign result       = res_q;
    assign status       = sts_q;
    assign result_valid = state_q == SHOW;
    assign err          = err_q;
    assign state_dbg    = state_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        sts_d   = sts_q;
        err_d   = 1'b0;
        if (acc && is_clr) begin
            state_d = IDLE;
            a_d     = '0;
            b_d     = '0;
            op_d    = OP_ADD;
            res_d   = '0;
            sts_d   = 1'b0;
        end else if (acc && is_bad) begin
            err_d = 1'b1;
        end else if (acc) begin
            case (state_q)
                IDLE:    if (is_dig) begin a_d = key_code[1:0]; state_d = GOT_A; end
                         else err_d = 1'b1;
                GOT_A:   if (is_dig) a_d = key_code[1:0];
                         else if (is_op) begin op_d = 2'(key_code - KEY_ADD); state_d = GOT_OP; end
                         else err_d = 1'b1;
                GOT_OP:  if (is_op) op_d = 2'(key_code - KEY_ADD);
                         else if (is_dig) begin b_d = key_code[1:0]; state_d = GOT_B; end
                         else err_d = 1'b1;
                GOT_B:   if (is_dig) b_d = key_code[1:0];
                         else if (is_eq) state_d = EXEC;
                         else err_d = 1'b1;
                SHOW:    if (is_dig) begin a_d = key_code[1:0]; b_d = '0; op_d = OP_ADD; state_d = GOT_A; end
                         else err_d = 1'b1;
                default: ;
            endcase
        end else if (state_q == EXEC) begin
            res_d   = alu_result;
            sts_d   = alu_status;
            state_d = SHOW;
        end else if (timeout) begin
            state_d = IDLE;
        end
        cnt_d = state_q == EXEC ? '0
              : (state_q == SHOW && state_d == SHOW) ? cnt_q + CNT_W'(1)
              : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            sts_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            sts_q   <= sts_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
